// File: rtl/apu_framectl.sv
// APU $4015/$4017 register front-end: channel enables, status read, frame-counter mode delay.
// Define APU_FRAMECTL_WRITE_DELAY_EN for the 3/4-cycle $4017 write delay; otherwise it applies next cycle.
module apu_framectl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] reg_addr,
    input  logic       reg_wr,
    input  logic       reg_rd,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic       rd_hit,
    input  logic       apu_cycle,
    input  logic       frame_irq,
    input  logic       dmc_irq,
    input  logic [4:0] len_active,
    output logic [4:0] chan_en,
    output logic       dmc_irq_clr,
    output logic       fc_mode,
    output logic       fc_interrupt_en,
    output logic       fc_update,
    output logic       fc_clrint
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 3;

    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(5'h15);
    localparam logic [ADDR_W-1:0] ADDR_FRAME  = ADDR_W'(5'h17);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_APPLY
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              pend_mode;

    logic              wr_status;
    logic              rd_status;
    logic              wr_frame;
    logic              wait_direct;
    logic [CNT_W-1:0]  wait_load;
    logic              unused_bits;

    // Register decode; only $4015 and $4017 respond.
    always_comb begin
        wr_status = reg_wr && (reg_addr == ADDR_STATUS);
        rd_status = reg_rd && (reg_addr == ADDR_STATUS);
        wr_frame  = reg_wr && (reg_addr == ADDR_FRAME);
    end

`ifdef APU_FRAMECTL_WRITE_DELAY_EN
    // Load value is the number of WAIT cycles before APPLY minus one.
    assign wait_direct = 1'b0;
    assign wait_load   = apu_cycle ? CNT_W'(1) : CNT_W'(2);
    assign unused_bits = reg_wdata[5];
`else
    assign wait_direct = 1'b1;
    assign wait_load   = '0;
    assign unused_bits = reg_wdata[5] ^ apu_cycle;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            pend_mode       <= 1'b0;
            chan_en         <= '0;
            reg_rdata       <= '0;
            rd_hit          <= 1'b0;
            dmc_irq_clr     <= 1'b0;
            fc_mode         <= 1'b0;
            fc_interrupt_en <= 1'b1;
            fc_update       <= 1'b0;
            fc_clrint       <= 1'b0;
        end else begin
            dmc_irq_clr <= wr_status;
            rd_hit      <= rd_status;
            fc_clrint   <= rd_status | (wr_frame & reg_wdata[6]);
            fc_update   <= 1'b0;

            if (wr_status) begin
                chan_en <= reg_wdata[4:0];
            end
            // Sampled in the strobe cycle, so the read sees the flag before fc_clrint lands.
            if (rd_status) begin
                reg_rdata <= {dmc_irq, frame_irq, 1'b0, len_active};
            end
            if (wr_frame) begin
                fc_interrupt_en <= ~reg_wdata[6];
            end

            // A new $4017 write always restarts the sequence and drops any pending mode.
            if (wr_frame) begin
                pend_mode <= reg_wdata[7];
                if (wait_direct) begin
                    state     <= ST_APPLY;
                    wait_cnt  <= '0;
                    fc_mode   <= reg_wdata[7];
                    fc_update <= 1'b1;
                end else begin
                    state    <= ST_WAIT;
                    wait_cnt <= wait_load;
                end
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (wait_cnt == '0) begin
                            state     <= ST_APPLY;
                            fc_mode   <= pend_mode;
                            fc_update <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - CNT_W'(1);
                        end
                    end
                    ST_APPLY: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        wait_cnt <= (wait_cnt != '0) ? wait_cnt - CNT_W'(1) : '0;
                    end
                endcase
            end
        end
    end

endmodule
